// File: rtl/shared_mem_pkg.sv
// Shared definitions for the multi-channel shared memory: default geometry,
// byte-offset shift and the grant-to-channel-id helper.
package mem_defs;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_DEPTH      = 1024;
    localparam int DEF_NCH        = 2;
    localparam int DEF_LATENCY    = 1;
    localparam int DEF_BYTE_SHIFT = $clog2(DEF_WIDTH / 8);

    localparam int MAX_NCH = 8;
    localparam int CH_W    = 3;

    function automatic int byte_shift(input int width);
        return $clog2(width / 8);
    endfunction

    // OR-reduction encoder; the input is guaranteed one-hot or zero.
    function automatic logic [CH_W-1:0] onehot_to_idx(input logic [MAX_NCH-1:0] oh);
        logic [CH_W-1:0] idx;
        idx = {CH_W{1'b0}};
        for (int i = 0; i < MAX_NCH; i++) begin
            if (oh[i]) begin
                idx = idx | CH_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/shared_mem_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// rotating pointer; the pointer moves past the winner whenever a grant is made.
module rr_arbiter
    import mem_defs::*;
#(
    parameter int NCH = DEF_NCH
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] req_i,
    output logic [NCH-1:0] grant_o
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win_s;
    logic          found_s;

    // Scanning 2*NCH positions from the pointer unrolls the wrap-around search.
    always_comb begin
        grant_o = {NCH{1'b0}};
        win_s   = {PW{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < 2 * NCH; i++) begin
            if (!found_s && req_i[i % NCH] && (i >= int'(ptr_q))) begin
                found_s           = 1'b1;
                grant_o[i % NCH]  = 1'b1;
                win_s             = PW'(i % NCH);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next pointer: one past the winner, or hold when nothing was granted.
    always_comb begin
        ptr_d = ptr_q;
        if (found_s) begin
            if (win_s == PW'(NCH - 1)) begin
                ptr_d = {PW{1'b0}};
            end else begin
                ptr_d = win_s + PW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= {PW{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/shared_mem.sv
// Multi-channel shared memory: one round-robin access per cycle, byte-enabled
// writes, fixed-latency in-order responses routed back to the requesting channel.
module shared_mem
    import mem_defs::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int NCH     = DEF_NCH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         req_valid,
    output logic [NCH-1:0]         req_ready,
    input  logic [NCH-1:0]         req_we,
    input  logic [NCH*WIDTH-1:0]   req_addr,
    input  logic [NCH*WIDTH-1:0]   req_wdata,
    input  logic [NCH*WIDTH/8-1:0] req_be,
    output logic [NCH-1:0]         rsp_valid,
    output logic [NCH*WIDTH-1:0]   rsp_rdata,
    output logic [NCH-1:0]         rsp_err
);

    localparam int NB    = WIDTH / 8;
    localparam int SHIFT = byte_shift(WIDTH);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic             valid;
        logic [CH_W-1:0]  ch;
        logic             err;
        logic [WIDTH-1:0] rdata;
    } rsp_stage_t;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [NCH-1:0]   arb_req_s;
    logic [NCH-1:0]   grant_s;
    logic             accept_s;
    logic             sel_we_s;
    logic [WIDTH-1:0] sel_addr_s;
    logic [WIDTH-1:0] sel_wdata_s;
    logic [NB-1:0]    sel_be_s;
    logic [WIDTH-1:0] word_s;
    logic [AW-1:0]    idx_s;
    logic             oor_s;
    rsp_stage_t       acc_s;
    rsp_stage_t       tail_s;

    logic [NCH-1:0]       rsp_valid_q, rsp_valid_d;
    logic [NCH-1:0]       rsp_err_q, rsp_err_d;
    logic [NCH*WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    assign arb_req_s = req_valid & {NCH{~reset}};

    rr_arbiter #(.NCH(NCH)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_i   (arb_req_s),
        .grant_o (grant_s)
    );

    assign req_ready = grant_s;
    assign accept_s  = |grant_s;

    // Route the granted channel's request fields to the memory port.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {WIDTH{1'b0}};
        sel_wdata_s = {WIDTH{1'b0}};
        sel_be_s    = {NB{1'b0}};
        for (int c = 0; c < NCH; c++) begin
            if (grant_s[c]) begin
                sel_we_s    = req_we[c];
                sel_addr_s  = req_addr[c*WIDTH +: WIDTH];
                sel_wdata_s = req_wdata[c*WIDTH +: WIDTH];
                sel_be_s    = req_be[c*NB +: NB];
            end else begin
                sel_we_s = sel_we_s;
            end
        end
    end

    assign word_s = sel_addr_s >> SHIFT;
    assign oor_s  = (64'(word_s) >= 64'(DEPTH));
    assign idx_s  = word_s[AW-1:0];

    // Reads see every write from earlier cycles because the array is read before this edge.
    always_comb begin
        acc_s.valid = accept_s;
        acc_s.ch    = onehot_to_idx(MAX_NCH'(grant_s));
        acc_s.err   = oor_s;
        if (!sel_we_s && !oor_s) begin
            acc_s.rdata = mem_q[idx_s];
        end else begin
            acc_s.rdata = {WIDTH{1'b0}};
        end
    end

    // Byte-enabled write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (accept_s && sel_we_s && !oor_s) begin
            for (int b = 0; b < NB; b++) begin
                if (sel_be_s[b]) begin
                    mem_q[idx_s][b*8 +: 8] <= sel_wdata_s[b*8 +: 8];
                end
            end
        end
    end

    // The output registers form the last stage, so only LATENCY-1 inner stages exist.
    if (LATENCY == 1) begin : g_lat1
        assign tail_s = acc_s;
    end else begin : g_pipe
        rsp_stage_t pipe_q [LATENCY-1];

        // Response delay line; reset drops every in-flight response.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < LATENCY - 1; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0] <= acc_s;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign tail_s = pipe_q[LATENCY-2];
    end

    // Steer the emerging response to its channel; other channels hold data and err.
    always_comb begin
        rsp_valid_d = {NCH{1'b0}};
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        for (int c = 0; c < NCH; c++) begin
            if (tail_s.valid && (tail_s.ch == CH_W'(c))) begin
                rsp_valid_d[c]                 = 1'b1;
                rsp_err_d[c]                   = tail_s.err;
                rsp_rdata_d[c*WIDTH +: WIDTH]  = tail_s.rdata;
            end else begin
                rsp_valid_d[c] = 1'b0;
            end
        end
    end

    // Response output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= {NCH{1'b0}};
            rsp_err_q   <= {NCH{1'b0}};
            rsp_rdata_q <= {(NCH*WIDTH){1'b0}};
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_shared_mem.sv
// Self-checking bench for shared_mem (4 channels, latency 3) against a
// behavioural model: word array, round-robin pointer and per-channel response queues.
module tb_shared_mem;

    localparam int W  = 32;
    localparam int D  = 64;
    localparam int N  = 4;
    localparam int L  = 3;
    localparam int NB = W / 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid, req_ready, req_we;
    logic [N*W-1:0]   req_addr, req_wdata;
    logic [N*NB-1:0]  req_be;
    logic [N-1:0]     rsp_valid, rsp_err;
    logic [N*W-1:0]   rsp_rdata;

    always #5 clk = ~clk;

    shared_mem #(.WIDTH(W), .DEPTH(D), .NCH(N), .LATENCY(L)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        int           due;
        logic [W-1:0] rd;
        logic         err;
    } exp_t;

    exp_t         expq [N][$];
    logic [W-1:0] mmem [D];
    logic [W-1:0] hold_rd [N];
    logic         hold_err [N];
    int           ptr_m;
    int           edges;
    int           n_pass;
    int           n_fail;
    int           n_total;

    logic [N-1:0]  v_s, we_s;
    logic [W-1:0]  a_s [N];
    logic [W-1:0]  d_s [N];
    logic [NB-1:0] be_s [N];
    logic [N-1:0]  ready_seen;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            expq[c].delete();
            hold_rd[c]  = '0;
            hold_err[c] = 1'b0;
        end
        ptr_m = 0;
    endtask

    task automatic set_req(input int c, input logic we, input logic [W-1:0] a,
                           input logic [W-1:0] d, input logic [NB-1:0] be);
        v_s[c]  = 1'b1;
        we_s[c] = we;
        a_s[c]  = a;
        d_s[c]  = d;
        be_s[c] = be;
    endtask

    task automatic rand_req(input int c);
        logic [W-1:0] word;
        word = W'($urandom_range(0, D + 7));
        if ($urandom_range(0, 15) == 0) begin
            word = 32'h3FFF_FFF0 | W'($urandom_range(0, 15));
        end
        set_req(c, 1'($urandom_range(0, 1)), (word << 2) | W'($urandom_range(0, 3)),
                W'($urandom), NB'($urandom_range(0, 15)));
    endtask

    task automatic check_rsp();
        for (int c = 0; c < N; c++) begin
            if (expq[c].size() > 0 && expq[c][0].due == edges) begin
                chk($sformatf("rsp_valid[%0d]", c), W'(rsp_valid[c]), 32'd1);
                chk($sformatf("rsp_rdata[%0d]", c), rsp_rdata[c*W +: W], expq[c][0].rd);
                chk($sformatf("rsp_err[%0d]", c), W'(rsp_err[c]), W'(expq[c][0].err));
                hold_rd[c]  = expq[c][0].rd;
                hold_err[c] = expq[c][0].err;
                void'(expq[c].pop_front());
            end else begin
                chk($sformatf("idle_valid[%0d]", c), W'(rsp_valid[c]), 32'd0);
                chk($sformatf("hold_rdata[%0d]", c), rsp_rdata[c*W +: W], hold_rd[c]);
                chk($sformatf("hold_err[%0d]", c), W'(rsp_err[c]), W'(hold_err[c]));
            end
        end
    endtask

    // One clock: drive requests, check ready and responses at the falling edge,
    // then apply the accepted request to the model at the rising edge.
    task automatic step(output int g);
        logic [N-1:0] exp_ready;
        logic [W-1:0] wi;
        exp_t         e;
        for (int c = 0; c < N; c++) begin
            req_valid[c]          = v_s[c];
            req_we[c]             = we_s[c];
            req_addr[c*W +: W]    = a_s[c];
            req_wdata[c*W +: W]   = d_s[c];
            req_be[c*NB +: NB]    = be_s[c];
        end
        g = -1;
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                if (g < 0 && v_s[(ptr_m + i) % N]) g = (ptr_m + i) % N;
            end
        end
        @(negedge clk);
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", W'(req_ready), W'(exp_ready));
        ready_seen = req_ready;
        check_rsp();
        @(posedge clk);
        edges++;
        if (g >= 0) begin
            wi    = a_s[g] >> 2;
            e.due = edges + L - 1;
            e.err = (wi >= W'(D));
            e.rd  = '0;
            if (!e.err) begin
                if (!we_s[g]) begin
                    e.rd = mmem[wi];
                end else begin
                    for (int b = 0; b < NB; b++) begin
                        if (be_s[g][b]) mmem[wi][b*8 +: 8] = d_s[g][b*8 +: 8];
                    end
                end
            end
            expq[g].push_back(e);
            ptr_m = (g + 1) % N;
        end
        #1;
    endtask

    task automatic drain();
        int g;
        v_s = '0;
        for (int k = 0; k < L + 2; k++) step(g);
    endtask

    initial begin
        int g;
        n_pass = 0; n_fail = 0; n_total = 0; edges = 0;
        reset = 1'b1;
        v_s = '0; we_s = '0;
        for (int c = 0; c < N; c++) begin
            a_s[c] = '0; d_s[c] = '0; be_s[c] = '0;
        end
        model_reset();
        @(posedge clk);
        #1;
        step(g);
        step(g);
        reset = 1'b0;

        // Fill every word so later reads have known contents.
        for (int w = 0; w < D; w++) begin
            set_req(0, 1'b1, W'(w * 4), W'($urandom), 4'hF);
            step(g);
        end
        drain();

        // Write then read back on channel 1 the very next cycle.
        set_req(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        step(g);
        set_req(1, 1'b0, 32'h10, 32'h0, 4'hF);
        step(g);
        drain();

        // Single-byte write merges into the existing word.
        set_req(1, 1'b1, 32'h10, 32'h0000_00AA, 4'h1);
        step(g);
        set_req(1, 1'b0, 32'h13, 32'h0, 4'h0);
        step(g);
        drain();

        // Channels 0 and 1 both requesting: grants must alternate 0,1,...
        set_req(0, 1'b0, 32'h20, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h10, 32'h0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            step(g);
            chk("alt01_grant", W'(ready_seen), (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        drain();

        // Channels 2 and 3 only: grants alternate 2,3 with no idle cycle.
        set_req(2, 1'b0, 32'h44, 32'h0, 4'h0);
        set_req(3, 1'b0, 32'h48, 32'h0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            step(g);
            chk("alt23_grant", W'(ready_seen), (k % 2 == 0) ? 32'd4 : 32'd8);
        end
        drain();

        // Out-of-range read and write, then read every word back.
        set_req(0, 1'b0, W'(4 * D), 32'h0, 4'hF);
        step(g);
        set_req(0, 1'b1, W'(4 * D), 32'h1234_5678, 4'hF);
        step(g);
        v_s = '0;
        for (int w = 0; w < D; w++) begin
            set_req(3, 1'b0, W'(w * 4), 32'h0, 4'h0);
            step(g);
        end
        drain();

        // Reset one cycle after an acceptance must kill that response.
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(g);
        v_s = '0;
        step(g);
        reset = 1'b1;
        #1;
        model_reset();
        for (int c = 0; c < N; c++) begin
            chk($sformatf("rst_valid[%0d]", c), W'(rsp_valid[c]), 32'd0);
            chk($sformatf("rst_rdata[%0d]", c), rsp_rdata[c*W +: W], 32'd0);
            chk($sformatf("rst_err[%0d]", c), W'(rsp_err[c]), 32'd0);
        end
        step(g);
        step(g);
        reset = 1'b0;
        drain();

        // Randomised traffic; a request stays stable until it is granted.
        v_s = '0;
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < N; c++) begin
                if (!v_s[c] && $urandom_range(0, 2) != 0) rand_req(c);
            end
            step(g);
            if (g >= 0) v_s[g] = 1'b0;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/shared_mem.md
SHARED_MEM -- requirements
Module: shared_mem

Interface
REQ-001 Parameter WIDTH, default 32, data/address width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 1024, number of WIDTH-bit words.
REQ-003 Parameter NCH, default 2, number of requester channels (0 = instruction fetch, 1 = data); range 1..8.
REQ-004 Parameter LATENCY, default 1, cycles from request acceptance to response; range 1..4.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  NCH  per-channel request present.
REQ-008 req_ready  out  NCH  per-channel request accepted this cycle.
REQ-009 req_we  in  NCH  per-channel write (1) / read (0).
REQ-010 req_addr  in  NCH*WIDTH  per-channel byte address, channel c in bits [c*WIDTH +: WIDTH].
REQ-011 req_wdata  in  NCH*WIDTH  per-channel write data.
REQ-012 req_be  in  NCH*WIDTH/8  per-channel byte enables, bit i writes byte i.
REQ-013 rsp_valid  out  NCH  per-channel response strobe, one cycle.
REQ-014 rsp_rdata  out  NCH*WIDTH  per-channel read data.
REQ-015 rsp_err  out  NCH  per-channel out-of-range flag, qualified by rsp_valid.

Function
REQ-016 Arbitration SHALL be round-robin: search starts at pointer ptr, first channel with req_valid=1 is granted; at most one grant per cycle.
REQ-017 req_ready SHALL be combinational, 1 only for the granted channel; a request is accepted when req_valid & req_ready.
REQ-018 After an acceptance, ptr SHALL become (granted channel + 1) mod NCH; with no acceptance, ptr SHALL hold.
REQ-019 Requesters SHALL hold request fields stable while req_valid=1 and req_ready=0; the block SHALL not sample them otherwise.
REQ-020 Word index SHALL be req_addr >> log2(WIDTH/8); low address bits SHALL be ignored.
REQ-021 Word index >= DEPTH SHALL be out-of-range: no write, response with rsp_err=1 and rsp_rdata=0.
REQ-022 An accepted in-range write SHALL update only the bytes whose req_be bit is 1, at the accepting clock edge.
REQ-023 Every accepted request, read or write, SHALL produce exactly one response on its own channel exactly LATENCY cycles after acceptance.
REQ-024 A read response SHALL carry the word as it stood after all writes accepted in earlier cycles (a read accepted the cycle after a write to the same word returns the new data).
REQ-025 A write response SHALL have rsp_rdata=0 and rsp_err per REQ-021.
REQ-026 Responses SHALL have no backpressure; a new request may be accepted every cycle (full throughput) and responses SHALL appear in acceptance order.
REQ-027 Between responses, rsp_valid SHALL be 0 and rsp_rdata/rsp_err of that channel SHALL hold their last values.
REQ-028 With NCH=1, the block SHALL behave as a single-port memory with req_ready = req_valid.

Reset
REQ-029 On reset assertion, rsp_valid, rsp_err, rsp_rdata and ptr SHALL clear to 0 immediately; all in-flight response stages SHALL be discarded.
REQ-030 Memory contents SHALL not be cleared by reset; a write accepted at the same edge where reset asserts SHALL not be guaranteed.
REQ-031 req_ready SHALL be 0 while reset is high.

Structure
REQ-032 Shared package/header mem_defs SHALL hold default WIDTH, DEPTH, NCH, LATENCY and the byte-offset shift constant.
REQ-033 Arbitration SHALL be a sub-module rr_arbiter (NCH requests in, one-hot grant out, pointer state internal).
REQ-034 Response delay SHALL be a LATENCY-stage pipeline carrying valid, channel id, err and read data.

Verification
REQ-035 Reset, then ch1 writes 0xDEADBEEF to 0x10 with be=0xF, ch1 reads 0x10 next cycle -> read rsp_rdata=0xDEADBEEF on ch1 LATENCY cycles later.
REQ-036 Word 0x10=0xDEADBEEF, write 0x000000AA with be=0x1, read -> 0xDEADBEAA.
REQ-037 Both channels valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; each channel receives 3 responses in order.
REQ-038 Read of address 4*DEPTH -> rsp_err=1, rsp_rdata=0; write there leaves words 0..DEPTH-1 unchanged.
REQ-039 LATENCY=3, reset asserted 1 cycle after an acceptance -> no rsp_valid ever appears for that request; outputs 0.
REQ-040 NCH=4, only ch2 and ch3 requesting -> grants alternate 2,3 with no idle cycles.
